// File: rtl/apb_rr_scheduler_pkg.sv
// Shared widths, FSM encodings and helpers for the round-robin APB scheduler.
// Imported by the scheduler top, its arbiter and its checker.
package apb_rr_scheduler_pkg;

    localparam int APB_ADDR_WIDTH = 16;
    localparam int APB_DATA_WIDTH = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // Index reached by stepping offs places beyond base on a ring of n requesters.
    function automatic int rr_wrap(input int base, input int offs, input int n);
        return (base + offs) % n;
    endfunction

endpackage

// File: rtl/apb_rr_scheduler_chk.sv
// Protocol checker for the scheduler: the granted requester keeps req high
// for as long as its transfer occupies the bus.
module apb_rr_scheduler_chk #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
)(
    input logic            pclk,
    input logic            rstn,
    input logic            psel,
    input logic [NREQ-1:0] req,
    input logic [IDXW-1:0] gnt_idx
);

    a_req_held: assert property (@(posedge pclk) disable iff (!rstn) psel |-> req[gnt_idx])
        else $error("granted requester dropped req mid-transfer");

endmodule

// File: rtl/apb_rr_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester strictly after ptr,
// wrapping past NREQ-1 back to 0.
module rr_arbiter
    import apb_rr_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
)(
    input  logic [NREQ-1:0] eligible,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            any_valid
);

    int idx_s;

    // Scan the ring starting one past ptr; the first hit wins and later hits are ignored.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        any_valid = 1'b0;
        idx_s     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_s = rr_wrap(int'(ptr), k, NREQ);
            if (!any_valid && eligible[idx_s]) begin
                any_valid    = 1'b1;
                gnt[idx_s]   = 1'b1;
                gnt_idx      = IDXW'(idx_s);
            end else begin
                any_valid = any_valid;
            end
        end
    end

endmodule

// File: rtl/apb_rr_scheduler.sv
// Round-robin arbiter plus APB SETUP/ACCESS sequencer shared by NREQ requesters,
// with pready wait states, a wait-state timeout and a one-cycle ack per transfer.
module apb_rr_scheduler
    import apb_rr_scheduler_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int TIMEOUT    = 15
)(
    input  logic                       pclk,
    input  logic                       rstn,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_write,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic                       psel,
    output logic                       penable,
    output logic                       pwrite,
    output logic [ADDR_WIDTH-1:0]      paddr,
    output logic [DATA_WIDTH-1:0]      pwdata,
    input  logic [DATA_WIDTH-1:0]      prdata,
    input  logic                       pready,
    input  logic                       pslverr
);

    localparam int              IDXW    = $clog2(NREQ);
    localparam int              WCW     = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0]  WC_LAST = WCW'(TIMEOUT - 1);
    localparam logic [IDXW-1:0] PTR_RST = IDXW'(NREQ - 1);

    logic [1:0]      state_r;
    logic [IDXW-1:0] ptr_r;
    logic [NREQ-1:0] gnt_r;
    logic [WCW-1:0]  wcnt_r;

    logic [NREQ-1:0] eligible_s;
    logic [NREQ-1:0] gnt_s;
    logic [IDXW-1:0] gnt_idx_s;
    logic            any_s;

    // The requester being acked this cycle is masked so it cannot be re-granted before dropping req.
    assign eligible_s = req & ~ack;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .eligible  (eligible_s),
        .ptr       (ptr_r),
        .gnt       (gnt_s),
        .gnt_idx   (gnt_idx_s),
        .any_valid (any_s)
    );

    assign psel    = (state_r != ST_IDLE);
    assign penable = (state_r == ST_ACCESS);

    // Sequencer, grant pointer, wait counter, latched APB request and response registers.
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            ptr_r     <= PTR_RST;
            gnt_r     <= '0;
            wcnt_r    <= '0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            ack       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            ack <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        state_r <= ST_SETUP;
                        ptr_r   <= gnt_idx_s;
                        gnt_r   <= gnt_s;
                        pwrite  <= req_write[gnt_idx_s];
                        paddr   <= req_addr[gnt_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
                        pwdata  <= req_wdata[gnt_idx_s*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    state_r <= ST_ACCESS;
                    wcnt_r  <= '0;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        state_r   <= ST_IDLE;
                        ack       <= gnt_r;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= pslverr;
                    end else if (wcnt_r == WC_LAST) begin
                        state_r   <= ST_IDLE;
                        ack       <= gnt_r;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        wcnt_r <= wcnt_r + WCW'(1);
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    apb_rr_scheduler_chk #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_chk (
        .pclk    (pclk),
        .rstn    (rstn),
        .psel    (psel),
        .req     (req),
        .gnt_idx (ptr_r)
    );

endmodule
